// File: rtl/clk_ratio_monitor_if.sv
// Signal bundle between a clock-health controller and one clk_ratio_monitor.
// The controller side is the master; the monitor itself is the slave.
interface clk_ratio_monitor_if #(
    parameter int CNT_W = 10
);
    logic             enable;
    logic             clk_in;
    logic [CNT_W-1:0] expected;
    logic [3:0]       tolerance;
    logic             err_clr;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_cycles;
    logic [CNT_W-1:0] high_cycles;
    logic             locked;
    logic             error;
    logic             timeout;

    modport master (
        output enable, clk_in, expected, tolerance, err_clr,
        input  meas_valid, meas_cycles, high_cycles, locked, error, timeout
    );

    modport slave (
        input  enable, clk_in, expected, tolerance, err_clr,
        output meas_valid, meas_cycles, high_cycles, locked, error, timeout
    );
endinterface

// File: rtl/clk_ratio_monitor.sv
// Measures sys_clk cycles per NUM_PERIODS periods of a sampled divided clock and
// reports lock, sticky error and timeout against a programmed expectation.
module clk_ratio_monitor #(
    parameter int CNT_W       = 10,
    parameter int NUM_PERIODS = 2,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    clk_ratio_monitor_if.slave mon
);
    localparam int EDGE_W = (NUM_PERIODS > 1) ? $clog2(NUM_PERIODS) : 1;
    localparam int GC_W   = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       hcnt_q;
    logic [EDGE_W-1:0]      edges_q;
    logic                   meas_valid_q;
    logic [CNT_W-1:0]       meas_q;
    logic [CNT_W-1:0]       high_q;
    logic                   timeout_q;
    logic [GC_W-1:0]        gc_q, gc_d;
    logic                   locked_q, locked_d;
    logic                   error_q, error_d;

    logic sync_w, rise, closing, tmo_now, good;

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    function automatic logic [GC_W-1:0] sat_inc(input logic [GC_W-1:0] v);
        return (v >= GC_W'(LOCK_COUNT)) ? GC_W'(LOCK_COUNT) : v + 1'b1;
    endfunction

    assign sync_w  = sync_q[SYNC_STAGES-1];
    assign rise    = sync_w & ~sync_d_q;
    assign closing = (state_q == MEAS) && rise && (edges_q == EDGE_W'(NUM_PERIODS - 1));
    assign tmo_now = (state_q == MEAS) && !closing && (cnt_q == '1);
    assign good    = abs_diff(meas_q, mon.expected) <= (CNT_W + 1)'(mon.tolerance);

    // Lock/error bookkeeping; a new error outranks err_clr in the same cycle.
    always_comb begin
        gc_d     = gc_q;
        locked_d = locked_q;
        error_d  = mon.err_clr ? 1'b0 : error_q;
        if (!mon.enable) begin
            gc_d     = '0;
            locked_d = 1'b0;
        end else if (tmo_now) begin
            gc_d     = '0;
            locked_d = 1'b0;
            error_d  = 1'b1;
        end else if (meas_valid_q) begin
            if (good) begin
                gc_d     = sat_inc(gc_q);
                locked_d = (sat_inc(gc_q) == GC_W'(LOCK_COUNT));
            end else begin
                gc_d     = '0;
                locked_d = 1'b0;
                error_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            sync_d_q     <= 1'b0;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            edges_q      <= '0;
            meas_valid_q <= 1'b0;
            meas_q       <= '0;
            high_q       <= '0;
            timeout_q    <= 1'b0;
            gc_q         <= '0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], mon.clk_in};
            sync_d_q     <= sync_w;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            gc_q         <= gc_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            if (!mon.enable) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                hcnt_q  <= '0;
                edges_q <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARM;
                    ARM: begin
                        if (rise) begin
                            state_q <= MEAS;
                            cnt_q   <= CNT_W'(1);
                            edges_q <= '0;
                            hcnt_q  <= CNT_W'(sync_w);
                        end
                    end
                    MEAS: begin
                        // The closing edge also opens the next window.
                        if (closing) begin
                            meas_q       <= cnt_q;
                            high_q       <= hcnt_q;
                            meas_valid_q <= 1'b1;
                            cnt_q        <= CNT_W'(1);
                            edges_q      <= '0;
                            hcnt_q       <= CNT_W'(sync_w);
                        end else if (tmo_now) begin
                            timeout_q <= 1'b1;
                            state_q   <= ARM;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            hcnt_q <= hcnt_q + CNT_W'(sync_w);
                            if (rise) edges_q <= edges_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mon.meas_valid  = meas_valid_q;
    assign mon.meas_cycles = meas_q;
    assign mon.high_cycles = high_q;
    assign mon.locked      = locked_q;
    assign mon.error       = error_q;
    assign mon.timeout     = timeout_q;
endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: directed scenarios then random clk_in waveforms,
// scored against a window-level reference model through an event queue.
module tb_clk_ratio_monitor;
    localparam int CNT_W  = 4;
    localparam int NP     = 2;
    localparam int SS     = 2;
    localparam int LOCK   = 4;
    localparam int MAXCNT = (1 << CNT_W) - 1;
    localparam int HIST   = 20000;
    localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2;

    typedef struct {
        bit is_tmo;
        int meas;
        int high;
        bit lk;
        bit er;
    } item_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    clk_ratio_monitor_if #(.CNT_W(CNT_W)) bus ();

    clk_ratio_monitor #(
        .CNT_W(CNT_W), .NUM_PERIODS(NP), .SYNC_STAGES(SS), .LOCK_COUNT(LOCK)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .mon    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    item_t sbq[$];
    bit    wave[$];
    bit    vh[HIST];
    bit    sv[HIST];
    int    total = 0, bad = 0;
    int    n = 0, last_rst = -100;
    bit    d_rst, d_en, d_clr;
    int    d_exp, d_tol;
    int    m_mode = M_IDLE, m_ws = 0, m_edges = 0, m_high = 0, m_gc = 0, m_pm = 0, m_ph = 0;
    bit    m_pend = 0, m_lk = 0, m_er = 0;
    bit    mon_on = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, n);
        end
    endtask

    task automatic push_item(bit t, int ms, int hi, bit lk, bit er);
        item_t it;
        it.is_tmo = t; it.meas = ms; it.high = hi; it.lk = lk; it.er = er;
        sbq.push_back(it);
    endtask

    // Reference: windows are spans between every NP-th synchronized rising edge.
    task automatic model_eval();
        bit s, r, cl, tm, nl, ne;
        int ng, diff, cm, ch;
        s = (n >= SS && n - SS > last_rst) ? vh[n-SS] : 1'b0;
        sv[n] = s;
        r = s & ~((n > 0) ? sv[n-1] : 1'b0);
        if (d_rst) begin
            if (m_pend) push_item(0, m_pm, m_ph, 0, 0);
            m_mode = M_IDLE; m_pend = 0; m_gc = 0; m_lk = 0; m_er = 0; last_rst = n;
            return;
        end
        nl = m_lk; ng = m_gc; ne = d_clr ? 1'b0 : m_er; cl = 0; tm = 0; cm = 0; ch = 0;
        if (m_pend && d_en) begin
            diff = m_pm - d_exp;
            if (diff < 0) diff = -diff;
            if (diff <= d_tol) begin
                ng = (m_gc + 1 > LOCK) ? LOCK : m_gc + 1;
                nl = (ng == LOCK);
            end else begin
                ng = 0; nl = 0; ne = 1;
            end
        end
        if (!d_en) begin
            m_mode = M_IDLE; ng = 0; nl = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARM;
        end else if (m_mode == M_ARM) begin
            if (r) begin m_mode = M_MEAS; m_ws = n; m_edges = 0; m_high = 0; end
        end else begin
            if (r && m_edges == NP - 1) begin
                cl = 1; cm = n - m_ws; ch = m_high; m_ws = n; m_edges = 0; m_high = 0;
            end else if (n - m_ws == MAXCNT) begin
                tm = 1; m_mode = M_ARM; ng = 0; nl = 0; ne = 1;
            end else if (r) begin
                m_edges++;
            end
        end
        if (m_mode == M_MEAS) m_high += int'(s);
        if (m_pend) push_item(0, m_pm, m_ph, nl, ne);
        if (tm) push_item(1, 0, 0, nl, ne);
        m_pend = cl;
        if (cl) begin m_pm = cm; m_ph = ch; end
        m_gc = ng; m_lk = nl; m_er = ne;
    endtask

    task automatic cyc();
        bit ci;
        ci = (wave.size() > 0) ? wave.pop_front() : 1'b0;
        sys_rst       = d_rst;
        bus.enable    = d_en;
        bus.clk_in    = ci;
        bus.expected  = CNT_W'(d_exp);
        bus.tolerance = 4'(d_tol);
        bus.err_clr   = d_clr;
        vh[n] = ci;
        model_eval();
        @(posedge sys_clk);
        #1;
        n++;
        d_clr = 0;
    endtask

    task automatic push_per(int h, int l);
        for (int i = 0; i < h; i++) wave.push_back(1'b1);
        for (int i = 0; i < l; i++) wave.push_back(1'b0);
    endtask

    task automatic push45(int reps);
        for (int i = 0; i < reps; i++) begin
            push_per(2, 2);
            push_per(3, 2);
        end
    endtask

    task automatic drain();
        while (wave.size() > 0) cyc();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_meas_valid"}, bus.meas_valid, 0);
        check({tag, "_meas_cycles"}, bus.meas_cycles, 0);
        check({tag, "_high_cycles"}, bus.high_cycles, 0);
        check({tag, "_locked"}, bus.locked, 0);
        check({tag, "_error"}, bus.error, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
    endtask

    // Monitor: pops one expected event whenever the DUT pulses meas_valid or timeout.
    initial begin
        item_t it;
        forever begin
            @(negedge sys_clk);
            if (mon_on && (bus.meas_valid === 1'b1 || bus.timeout === 1'b1)) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: got meas_valid=%0b timeout=%0b, want no event (cycle %0d)",
                             bus.meas_valid, bus.timeout, n);
                end else begin
                    it = sbq.pop_front();
                    check("evt_type", {bus.meas_valid, bus.timeout}, it.is_tmo ? 2'b01 : 2'b10);
                    if (it.is_tmo) begin
                        check("tmo_locked", bus.locked, it.lk);
                        check("tmo_error", bus.error, it.er);
                    end else begin
                        check("meas_cycles", bus.meas_cycles, it.meas);
                        check("high_cycles", bus.high_cycles, it.high);
                        @(negedge sys_clk);
                        check("cmp_locked", bus.locked, it.lk);
                        check("cmp_error", bus.error, it.er);
                    end
                end
            end
        end
    end

    initial begin
        bit hit;
        d_rst = 1; d_en = 0; d_clr = 0; d_exp = 9; d_tol = 0;
        repeat (3) cyc();
        d_rst = 0;
        check_all_zero("reset");
        mon_on = 1;

        // /4.5 clock, exact expectation: lock after four windows
        d_en = 1;
        push45(7);
        drain();
        check("t1_locked", bus.locked, 1);
        check("t1_error", bus.error, 0);

        // wrong expectation outside tolerance, then clear
        d_exp = 12; d_tol = 2;
        push45(2);
        drain();
        check("t2_error", bus.error, 1);
        check("t2_locked", bus.locked, 0);
        d_exp = 9; d_tol = 0; d_clr = 1;
        cyc();
        check("t2_err_clr", bus.error, 0);

        // clk_in stuck low: timeout, then resume measuring
        repeat (20) cyc();
        check("t3_error", bus.error, 1);
        check("t3_locked", bus.locked, 0);
        push45(14);
        repeat (54) cyc();
        check("t4_locked_before", bus.locked, 1);

        // one-cycle enable drop while locked
        d_en = 0;
        cyc();
        d_en = 1;
        check("t4_locked_drop", bus.locked, 0);
        check("t4_meas_held", bus.meas_cycles, 9);
        drain();
        check("t4_relocked", bus.locked, 1);

        // err_clr coinciding with a bad compare
        push45(8);
        repeat (12) cyc();
        d_clr = 1;
        cyc();
        check("t5_cleared", bus.error, 0);
        d_exp = 3;
        hit = 0;
        while (wave.size() > 0) begin
            if (m_pend && !hit) begin
                d_clr = 1; hit = 1;
                cyc();
                check("t5_err_wins", bus.error, 1);
            end else begin
                cyc();
            end
        end
        check("t5_hit", hit, 1);

        // reset in the middle of a window
        d_exp = 9;
        push45(6);
        repeat (13) cyc();
        d_rst = 1;
        cyc();
        d_rst = 0;
        check_all_zero("t6");
        drain();

        // randomized waveforms and controls
        for (int i = 0; i < 2500; i++) begin
            if (wave.size() < 2) begin
                if ($urandom_range(0, 39) == 0) push_per(0, 20);
                else push_per($urandom_range(1, 4), $urandom_range(1, 4));
            end
            d_en  = ($urandom_range(0, 199) != 0);
            d_clr = ($urandom_range(0, 49) == 0);
            d_rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 29) == 0) d_exp = $urandom_range(4, 15);
            if ($urandom_range(0, 29) == 0) d_tol = $urandom_range(0, 3);
            cyc();
        end
        d_rst = 0; d_en = 0;
        repeat (5) cyc();
        check("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
